mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Sequences multi-cycle data-memory accesses for the MEM stage. It watches the memory controls leaving the EX/MEM pipeline register and issues one request per load/store on a req/ack data-memory port. While an access is in flight it stalls the front of the pipeline and bubbles the MEM/WB register. It also bounds each access with a timeout and reports faults.

## Interface
- DATA_WIDTH, 32, data path width
- ADDR_WIDTH, 32, address width
- TIMEOUT_CYCLES, 16, maximum BUSY cycles before fault (≥2)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- mem_MemRead  in  1  load in EX/MEM register
- mem_MemWrite  in  1  store in EX/MEM register
- mem_alu_result  in  ADDR_WIDTH  access address
- mem_rs2_data  in  DATA_WIDTH  store data
- dmem_req  out  1  memory request, held until ack/err/timeout
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_WIDTH  latched address
- dmem_wdata  out  DATA_WIDTH  latched store data
- dmem_ack  in  1  access complete
- dmem_err  in  1  access error
- dmem_rdata  in  DATA_WIDTH  read data, valid with ack
- pipe_stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM (drive their enable low)
- memwb_flush  out  1  insert bubble into MEM/WB (equals pipe_stall)
- load_data  out  DATA_WIDTH  latched read data (0 on fault)
- load_valid  out  1  one-cycle pulse, load completed
- access_fault  out  1  one-cycle pulse, err or timeout

## Operation
- FSM states: IDLE, BUSY, DONE. Reset → IDLE.
- access = mem_MemRead | mem_MemWrite. When both are set, the access is treated as a write.
- IDLE:
  - pipe_stall = access (combinational).
  - On access: latch dmem_addr, dmem_wdata, dmem_we, and is_read = mem_MemRead & ~mem_MemWrite. Clear the timeout counter. Go to BUSY.
- BUSY:
  - dmem_req = 1 and pipe_stall = 1.
  - dmem_err (with or without ack): go to DONE, fault = 1.
  - Else dmem_ack: latch load_data = dmem_rdata if is_read, go to DONE, fault = 0.
  - Else if counter == TIMEOUT_CYCLES-1: go to DONE, fault = 1.
  - Else counter += 1.
- DONE:
  - pipe_stall = 0, so the serviced instruction advances this cycle.
  - load_valid = is_read & ~fault.
  - access_fault = fault.
  - On a fault, load_data = 0.
  - Next state: IDLE, unconditionally.
- In IDLE, the next instruction in EX/MEM is evaluated afresh. Back-to-back accesses each incur their own BUSY sequence. An instruction is never re-issued because DONE always advances it.
- dmem_ack/dmem_err outside BUSY are ignored.
- Counter width: $clog2(TIMEOUT_CYCLES).
- dmem_addr, dmem_wdata and dmem_we are stable for the whole of BUSY.
- memwb_flush = pipe_stall at all times.
- exmem flush/branch flush does not abort an access already in BUSY; the upstream stall holds it.

## Timing
- Reset values (while rst high and after):
  - state IDLE, dmem_req 0, dmem_we 0.
  - dmem_addr 0, dmem_wdata 0, load_data 0.
  - load_valid 0, access_fault 0.
  - pipe_stall 0, memwb_flush 0 (forced 0 while rst asserted).
- Reset mid-BUSY: dmem_req drops asynchronously, and the latched access is discarded.
- Access seen in EX/MEM at cycle T:
  - pipe_stall is high in T.
  - BUSY from T+1, with dmem_req registered high from T+1.
- Ack in BUSY cycle T+k (k≥1): DONE at T+k+1, dmem_req low at T+k+1, and the instruction advances at the end of T+k+1.
- Stall cycles per access = k+1. The minimum is 2 (ack at T+1).
- Timeout with no ack: fault in DONE at T+TIMEOUT_CYCLES+1.
- Ack and timeout in the same cycle: ack wins, no fault.
- Ack and err in the same cycle: err wins.
- No access present: pipe_stall stays 0 and there is zero overhead.

## Test plan
- Load to addr 0x100, ack at T+1 with rdata 0xDEADBEEF → dmem_req high T+1 only, pipe_stall high T..T+1, load_valid pulse at T+2 with load_data 0xDEADBEEF.
- Store of 0x12345678 to 0x200, ack after 5 BUSY cycles → dmem_we=1, addr/wdata stable for 5 cycles, no load_valid, pipe_stall high for 6 cycles.
- Load with no ack, TIMEOUT_CYCLES=16 → dmem_req high 16 cycles, access_fault pulse at T+17, load_data 0, load_valid 0.
- Err and ack asserted together on a load → access_fault=1, load_valid=0, load_data 0. A separate case with ack arriving on the timeout cycle → no fault.
- Back-to-back load then store with immediate acks → two distinct requests, each stalling 2 cycles; the store is not issued before the load's DONE.
- rst asserted mid-BUSY → dmem_req drops without a clock edge, all outputs 0. The next access after release issues normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Runs one data-memory access for each load or store that reaches the MEM
// stage. The access is issued on a req/ack port. While it is outstanding the
// front of the pipeline is stalled and the MEM/WB register takes a bubble.
// A cycle counter limits how long an access can wait. Errors and timeouts are
// reported as a one-cycle fault pulse.

module mem_access_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  // memory controls leaving the EX/MEM register
  input  logic                  mem_MemRead,
  input  logic                  mem_MemWrite,
  input  logic [ADDR_WIDTH-1:0] mem_alu_result,
  input  logic [DATA_WIDTH-1:0] mem_rs2_data,
  // data-memory request port
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_ack,
  input  logic                  dmem_err,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  // pipeline control
  output logic                  pipe_stall,
  output logic                  memwb_flush,
  // completion reporting
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_valid,
  output logic                  access_fault
);

  // The counter only has to reach TIMEOUT_CYCLES-1. A width of at least one
  // bit keeps the degenerate parameter values legal.
  localparam int CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                  state_q;
  logic                    req_q;
  logic                    we_q;
  logic                    isRead_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   loadData_q;
  logic                    loadValid_q;
  logic                    fault_q;
  logic [CntW-1:0]         cnt_q;

  logic                    access;
  logic                    timeoutHit;
  logic                    stall;

  // A write wins when both controls are set, so any access counts here.
  // The last permitted BUSY cycle is the one where the counter reaches its
  // final value.
  always_comb begin
    access     = mem_MemRead | mem_MemWrite;
    timeoutHit = (cnt_q == CntLast);
  end

  // Stall rule: in IDLE, stall combinationally as soon as an access shows up,
  // so the instruction is held in the same cycle. In BUSY, always stall.
  // In DONE, release so the serviced instruction moves on. Reset forces the
  // stall low so a reset pipeline is never held.
  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE:    stall = access;
        BUSY:    stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  // Access sequencer. The request, the latched access, the completion pulses
  // and the timeout counter all change together in this one register block.
  // A fault always clears load_data, so a faulted load never exposes stale
  // data. A store without a fault leaves the previous load value in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      isRead_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      loadData_q  <= '0;
      loadValid_q <= 1'b0;
      fault_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      loadValid_q <= 1'b0;
      fault_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (access) begin
            state_q  <= BUSY;
            req_q    <= 1'b1;
            addr_q   <= mem_alu_result;
            wdata_q  <= mem_rs2_data;
            we_q     <= mem_MemWrite;
            isRead_q <= mem_MemRead & ~mem_MemWrite;
            cnt_q    <= '0;
          end
        end
        BUSY: begin
          if (dmem_err) begin
            state_q    <= DONE;
            req_q      <= 1'b0;
            fault_q    <= 1'b1;
            loadData_q <= '0;
          end else if (dmem_ack) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            if (isRead_q) begin
              loadData_q  <= dmem_rdata;
              loadValid_q <= 1'b1;
            end
          end else if (timeoutHit) begin
            state_q    <= DONE;
            req_q      <= 1'b0;
            fault_q    <= 1'b1;
            loadData_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // All outputs are driven straight from registers, except the stall, which
  // is a decode of the registered state plus the incoming access.
  always_comb begin
    dmem_req     = req_q;
    dmem_we      = we_q;
    dmem_addr    = addr_q;
    dmem_wdata   = wdata_q;
    load_data    = loadData_q;
    load_valid   = loadValid_q;
    access_fault = fault_q;
    pipe_stall   = stall;
    memwb_flush  = stall;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
// Directed bench for mem_access_ctrl. Each access pushes its expected
// completion onto a scoreboard queue. The entry is popped and compared when
// the DUT reaches its completion cycle.

module tb_mem_access_ctrl;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_MemRead;
  logic          mem_MemWrite;
  logic [AW-1:0] mem_alu_result;
  logic [DW-1:0] mem_rs2_data;
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_ack;
  logic          dmem_err;
  logic [DW-1:0] dmem_rdata;
  logic          pipe_stall;
  logic          memwb_flush;
  logic [DW-1:0] load_data;
  logic          load_valid;
  logic          access_fault;

  typedef struct {
    logic        valid;
    logic        fault;
    logic [31:0] data;
    int          reqCycles;
    int          stallCycles;
  } expT;

  expT         sbQ[$];
  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] expLoadData;

  mem_access_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_MemRead(mem_MemRead),
    .mem_MemWrite(mem_MemWrite),
    .mem_alu_result(mem_alu_result),
    .mem_rs2_data(mem_rs2_data),
    .dmem_req(dmem_req),
    .dmem_we(dmem_we),
    .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack),
    .dmem_err(dmem_err),
    .dmem_rdata(dmem_rdata),
    .pipe_stall(pipe_stall),
    .memwb_flush(memwb_flush),
    .load_data(load_data),
    .load_valid(load_valid),
    .access_fault(access_fault)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  // Compares one observed value with one expected value and records the result.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Keeps EX/MEM empty for n cycles and checks that no stall appears.
  task automatic applyIdle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mem_MemRead  = 1'b0;
      mem_MemWrite = 1'b0;
      #1;
      checkOutput("idleNoStall", {30'b0, pipe_stall, memwb_flush}, 32'h0);
    end
  endtask

  // Presents one access in EX/MEM and answers it at BUSY cycle ackAt
  // (1-based; 0 means never answer). When errWith is set, err is raised
  // together with ack.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rdata,
                               input int ackAt, input logic errWith);
    expT  e;
    expT  got;
    logic isRead;
    logic fault;
    logic stable;
    int   reqC;
    int   stallC;
    bit   done;
    isRead = rd & ~wr;
    fault  = (ackAt == 0) || errWith;
    if (fault)
      expLoadData = 32'h0;
    else if (isRead)
      expLoadData = rdata;
    e.valid       = isRead & ~fault;
    e.fault       = fault;
    e.data        = expLoadData;
    e.reqCycles   = (ackAt == 0) ? TO : ackAt;
    e.stallCycles = e.reqCycles + 1;
    sbQ.push_back(e);

    @(negedge clk);
    mem_MemRead    = rd;
    mem_MemWrite   = wr;
    mem_alu_result = addr;
    mem_rs2_data   = wdata;
    #1;
    checkOutput("stallOnAccess", {30'b0, pipe_stall, memwb_flush}, 32'h3);
    stallC = pipe_stall ? 1 : 0;
    reqC   = 0;
    stable = 1'b1;
    done   = 1'b0;
    for (int c = 1; c <= TO + 4 && !done; c++) begin
      @(negedge clk);
      dmem_ack = 1'b0;
      dmem_err = 1'b0;
      if (pipe_stall) stallC++;
      if (dmem_req) begin
        reqC++;
        if (dmem_addr !== addr || dmem_wdata !== wdata || dmem_we !== wr) stable = 1'b0;
        if (c == ackAt) begin
          dmem_ack   = 1'b1;
          dmem_err   = errWith;
          dmem_rdata = rdata;
        end
      end else begin
        done = 1'b1;
        got  = sbQ.pop_front();
        checkOutput("loadValid", {31'b0, load_valid}, {31'b0, got.valid});
        checkOutput("accessFault", {31'b0, access_fault}, {31'b0, got.fault});
        checkOutput("loadData", load_data, got.data);
        checkOutput("reqCycles", reqC, got.reqCycles);
        checkOutput("stallCycles", stallC, got.stallCycles);
        checkOutput("addrStable", {31'b0, stable}, 32'h1);
      end
    end
    if (!done) begin
      checkOutput("doneReached", 32'h0, 32'h1);
      void'(sbQ.pop_front());
    end
  endtask

  // Directed sequence of steps.
  initial begin
    rst            = 1'b1;
    mem_MemRead    = 1'b0;
    mem_MemWrite   = 1'b0;
    mem_alu_result = '0;
    mem_rs2_data   = '0;
    dmem_ack       = 1'b0;
    dmem_err       = 1'b0;
    dmem_rdata     = '0;
    expLoadData    = 32'h0;

    // Reset state is held while rst stays high.
    @(negedge clk);
    @(negedge clk);
    mem_MemRead = 1'b1;
    #1;
    checkOutput("rstStall", {30'b0, pipe_stall, memwb_flush}, 32'h0);
    checkOutput("rstReqWe", {30'b0, dmem_req, dmem_we}, 32'h0);
    checkOutput("rstAddr", dmem_addr, 32'h0);
    checkOutput("rstWdata", dmem_wdata, 32'h0);
    checkOutput("rstLoadData", load_data, 32'h0);
    checkOutput("rstPulses", {30'b0, load_valid, access_fault}, 32'h0);
    @(negedge clk);
    mem_MemRead = 1'b0;
    rst = 1'b0;
    applyIdle(3);

    // An ack outside BUSY must be ignored.
    @(negedge clk);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_ack = 1'b0;
    checkOutput("strayAckReq", {31'b0, dmem_req}, 32'h0);
    checkOutput("strayAckValid", {31'b0, load_valid}, 32'h0);
    checkOutput("strayAckData", load_data, 32'h0);

    // Load with an immediate ack.
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 1, 1'b0);
    applyIdle(1);
    // Store answered after five BUSY cycles.
    applyStimulus(1'b0, 1'b1, 32'h200, 32'h1234_5678, 32'h0, 5, 1'b0);
    applyIdle(1);
    // Load that is never answered times out.
    applyStimulus(1'b1, 1'b0, 32'h300, 32'h0, 32'h0, 0, 1'b0);
    applyIdle(1);
    // Load that succeeds first, so the next case can show load_data cleared.
    applyStimulus(1'b1, 1'b0, 32'h304, 32'h0, 32'h5555_AAAA, 2, 1'b0);
    // Err together with ack: err takes priority.
    applyStimulus(1'b1, 1'b0, 32'h308, 32'h0, 32'h7777_7777, 3, 1'b1);
    applyIdle(1);
    // Ack on the last timeout cycle: ack takes priority.
    applyStimulus(1'b1, 1'b0, 32'h30C, 32'h0, 32'hCAFE_F00D, TO, 1'b0);
    // Back-to-back load and store with immediate acks.
    applyStimulus(1'b1, 1'b0, 32'h400, 32'h0, 32'h1111_2222, 1, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h404, 32'hABCD_0123, 32'h0, 1, 1'b0);
    // Read and write both set: handled as a write.
    applyStimulus(1'b1, 1'b1, 32'h408, 32'h0BAD_F00D, 32'h9999_9999, 2, 1'b0);
    applyIdle(2);

    // Reset in the middle of BUSY drops the request with no clock edge.
    @(negedge clk);
    mem_MemRead    = 1'b1;
    mem_alu_result = 32'h500;
    @(negedge clk);
    @(negedge clk);
    checkOutput("midBusyReq", {31'b0, dmem_req}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncRstReq", {31'b0, dmem_req}, 32'h0);
    checkOutput("asyncRstStall", {30'b0, pipe_stall, memwb_flush}, 32'h0);
    checkOutput("asyncRstAddr", dmem_addr, 32'h0);
    checkOutput("asyncRstData", load_data, 32'h0);
    checkOutput("asyncRstPulses", {29'b0, load_valid, access_fault, dmem_we}, 32'h0);
    mem_MemRead = 1'b0;
    expLoadData = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    applyIdle(1);
    applyStimulus(1'b1, 1'b0, 32'h600, 32'h0, 32'h0000_A5A5, 2, 1'b0);
    applyIdle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
